// File: rtl/pbvi_pkg.sv
// Shared types, default parameters and helpers for the PBVI iteration controller.
package pbvi_pkg;

  localparam int DEF_N_POINTS  = 16;
  localparam int DEF_N_STATES  = 2;
  localparam int DEF_N_ACTIONS = 3;
  localparam int DEF_W         = 16;
  localparam int DEF_TIMEOUT   = 4096;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SCAN  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef logic signed [DEF_W-1:0] alpha_t;

  // |a - b| for sign-extended operands; one extra bit so the full signed
  // range difference (e.g. 0x7FFF - 0x8000) never wraps.
  function automatic logic [32:0] abs_diff(input logic signed [31:0] a,
                                           input logic signed [31:0] b);
    logic signed [32:0] d;
    d = {a[31], a} - {b[31], b};
    return d[32] ? 33'(-d) : 33'(d);
  endfunction

endpackage

// File: rtl/pbvi_iter_ctrl_if.sv
// Step interface between the iteration controller (master) and the backup engine (slave).
interface pbvi_iter_ctrl_if #(
  parameter int N_POINTS  = 16,
  parameter int N_STATES  = 2,
  parameter int N_ACTIONS = 3,
  parameter int W         = 16
);
  localparam int AW = (N_ACTIONS > 1) ? $clog2(N_ACTIONS) : 1;

  logic                                     step_en;
  logic [N_POINTS-1:0][N_STATES-1:0][W-1:0] step_alpha;
  logic                                     step_done;
  logic [N_POINTS-1:0][N_STATES-1:0][W-1:0] step_alpha_res;
  logic [N_POINTS-1:0][AW-1:0]              step_action_res;

  modport master (
    output step_en, step_alpha,
    input  step_done, step_alpha_res, step_action_res
  );

  modport slave (
    input  step_en, step_alpha,
    output step_done, step_alpha_res, step_action_res
  );
endinterface

// File: rtl/pbvi_conv_scan.sv
// Serial max-|difference| scanner: one element pair per valid cycle.
// result is the running maximum including the current element, so the
// caller can decide convergence in the same cycle that carries last.
module pbvi_conv_scan
  import pbvi_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                valid,
  input  logic                last,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic [W:0]          result,
  output logic                result_valid
);

  logic [32:0] diff_full;
  logic [W:0]  diff;
  logic [W:0]  base;
  logic [W:0]  max_reg;
  logic        unused_diff_hi;

  assign diff_full      = abs_diff(32'(a), 32'(b));
  assign diff           = diff_full[W:0];
  assign unused_diff_hi = ^diff_full[32:W+1];

  // A new scan starts from zero rather than the previous scan's maximum.
  assign base         = start ? '0 : max_reg;
  assign result       = (diff > base) ? diff : base;
  assign result_valid = valid & last;

  // Hold the running maximum between scan cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_reg <= '0;
    end else if (valid) begin
      max_reg <= result;
    end
  end

endmodule

// File: rtl/pbvi_iter_ctrl.sv
// PBVI iteration controller: drives the backup engine until the iteration
// budget runs out, the alpha set converges within epsilon, or the engine
// stops answering.
module pbvi_iter_ctrl
  import pbvi_pkg::*;
#(
  parameter int N_POINTS  = DEF_N_POINTS,
  parameter int N_STATES  = DEF_N_STATES,
  parameter int N_ACTIONS = DEF_N_ACTIONS,
  parameter int W         = DEF_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     start,
  input  logic                                     abort,
  input  logic [15:0]                              max_iter,
  input  logic [W-1:0]                             epsilon,
  input  logic [N_POINTS-1:0][N_STATES-1:0][W-1:0] alpha_in,
  pbvi_iter_ctrl_if.master                         step,
  output logic                                     busy,
  output logic                                     done,
  output logic                                     converged,
  output logic                                     timeout_err,
  output logic [15:0]                              iter_count,
  output logic [N_POINTS-1:0][N_STATES-1:0][W-1:0] alpha_out,
  output logic [N_POINTS-1:0][((N_ACTIONS > 1) ? $clog2(N_ACTIONS) : 1)-1:0] point_action
);

  localparam int AW = (N_ACTIONS > 1) ? $clog2(N_ACTIONS) : 1;
  localparam int PW = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
  localparam int SW = (N_STATES > 1) ? $clog2(N_STATES) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_LOAD  = ST_LOAD;
  localparam logic [2:0] S_ISSUE = ST_ISSUE;
  localparam logic [2:0] S_WAIT  = ST_WAIT;
  localparam logic [2:0] S_SCAN  = ST_SCAN;
  localparam logic [2:0] S_DONE  = ST_DONE;

  localparam logic [PW-1:0] PT_LAST   = PW'(N_POINTS - 1);
  localparam logic [SW-1:0] ST_LAST   = SW'(N_STATES - 1);
  localparam logic [TW-1:0] WDOG_LAST = TW'(TIMEOUT - 1);

  logic [2:0]                               state_reg;
  logic [N_POINTS-1:0][N_STATES-1:0][W-1:0] alpha_cur_reg;
  logic [N_POINTS-1:0][N_STATES-1:0][W-1:0] alpha_new_reg;
  logic [N_POINTS-1:0][AW-1:0]              act_new_reg;
  logic [N_POINTS-1:0][N_STATES-1:0][W-1:0] alpha_out_reg;
  logic [N_POINTS-1:0][AW-1:0]              point_action_reg;
  logic [15:0]                              iter_reg;
  logic                                     conv_reg;
  logic                                     tmo_reg;
  logic [TW-1:0]                            wdog_reg;
  logic [PW-1:0]                            pt_reg;
  logic [SW-1:0]                            st_reg;

  logic signed [W-1:0] scan_a;
  logic signed [W-1:0] scan_b;
  logic                scan_first;
  logic                scan_last;
  logic                scan_valid;
  logic [W:0]          scan_max;
  logic                scan_end;
  logic                conv_hit;

  assign scan_a     = alpha_new_reg[pt_reg][st_reg];
  assign scan_b     = alpha_cur_reg[pt_reg][st_reg];
  assign scan_first = (pt_reg == '0) && (st_reg == '0);
  assign scan_last  = (pt_reg == PT_LAST) && (st_reg == ST_LAST);
  assign scan_valid = (state_reg == S_SCAN);
  assign conv_hit   = (scan_max <= {1'b0, epsilon});

  pbvi_conv_scan #(.W(W)) u_scan (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (scan_first),
    .valid        (scan_valid),
    .last         (scan_last),
    .a            (scan_a),
    .b            (scan_b),
    .result       (scan_max),
    .result_valid (scan_end)
  );

  assign step.step_en    = (state_reg == S_ISSUE);
  assign step.step_alpha = alpha_cur_reg;
  assign busy            = (state_reg != S_IDLE);
  assign done            = (state_reg == S_DONE);
  assign converged       = conv_reg;
  assign timeout_err     = tmo_reg;
  assign iter_count      = iter_reg;
  assign alpha_out       = alpha_out_reg;
  assign point_action    = point_action_reg;

  // Main FSM with alpha buffers, watchdog and scan index; abort wins over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      alpha_cur_reg    <= '0;
      alpha_new_reg    <= '0;
      act_new_reg      <= '0;
      alpha_out_reg    <= '0;
      point_action_reg <= '0;
      iter_reg         <= '0;
      conv_reg         <= 1'b0;
      tmo_reg          <= 1'b0;
      wdog_reg         <= '0;
      pt_reg           <= '0;
      st_reg           <= '0;
    end else if (abort && (state_reg != S_IDLE)) begin
      state_reg <= S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            conv_reg  <= 1'b0;
            tmo_reg   <= 1'b0;
            iter_reg  <= '0;
            state_reg <= S_LOAD;
          end
        end
        S_LOAD: begin
          alpha_cur_reg <= alpha_in;
          if (max_iter == 16'd0) begin
            alpha_out_reg <= alpha_in;
            state_reg     <= S_DONE;
          end else begin
            state_reg <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wdog_reg  <= '0;
          pt_reg    <= '0;
          st_reg    <= '0;
          state_reg <= S_WAIT;
        end
        S_WAIT: begin
          if (step.step_done) begin
            alpha_new_reg <= step.step_alpha_res;
            act_new_reg   <= step.step_action_res;
            iter_reg      <= iter_reg + 16'd1;
            state_reg     <= S_SCAN;
          end else if (wdog_reg == WDOG_LAST) begin
            tmo_reg       <= 1'b1;
            alpha_out_reg <= alpha_cur_reg;
            state_reg     <= S_DONE;
          end else begin
            wdog_reg <= wdog_reg + TW'(1);
          end
        end
        S_SCAN: begin
          if (scan_end) begin
            if (conv_hit || (iter_reg == max_iter)) begin
              conv_reg         <= conv_hit;
              alpha_out_reg    <= alpha_new_reg;
              point_action_reg <= act_new_reg;
              state_reg        <= S_DONE;
            end else begin
              alpha_cur_reg <= alpha_new_reg;
              state_reg     <= S_ISSUE;
            end
          end else if (st_reg == ST_LAST) begin
            st_reg <= '0;
            pt_reg <= pt_reg + PW'(1);
          end else begin
            st_reg <= st_reg + SW'(1);
          end
        end
        S_DONE: begin
          state_reg <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pbvi_iter_ctrl.sv
// Scoreboard bench for pbvi_iter_ctrl: a behavioural engine answers step
// requests, a solve-level model predicts each result, and a monitor checks
// every done pulse against the expected-results queue.
module tb_pbvi_iter_ctrl;

  localparam int NP  = 16;
  localparam int NS  = 2;
  localparam int NA  = 3;
  localparam int W   = 16;
  localparam int TMO = 16;
  localparam int AW  = 2;

  localparam int M_PLUS1  = 0;
  localparam int M_IDENT  = 1;
  localparam int M_CONST  = 2;
  localparam int M_HALVE  = 3;
  localparam int M_SILENT = 4;

  typedef logic [NP-1:0][NS-1:0][W-1:0] alpha_vec_t;
  typedef logic [NP-1:0][AW-1:0]        act_vec_t;

  typedef struct {
    int         iters;
    bit         conv;
    bit         tmo;
    alpha_vec_t alpha;
    act_vec_t   act;
    int         lat;
    int         nstep;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] max_iter;
  logic [W-1:0] epsilon;
  alpha_vec_t  alpha_in;
  logic        busy;
  logic        done;
  logic        converged;
  logic        timeout_err;
  logic [15:0] iter_count;
  alpha_vec_t  alpha_out;
  act_vec_t    point_action;

  pbvi_iter_ctrl_if #(.N_POINTS(NP), .N_STATES(NS), .N_ACTIONS(NA), .W(W)) sif ();

  pbvi_iter_ctrl #(
    .N_POINTS(NP), .N_STATES(NS), .N_ACTIONS(NA), .W(W), .TIMEOUT(TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .max_iter     (max_iter),
    .epsilon      (epsilon),
    .alpha_in     (alpha_in),
    .step         (sif),
    .busy         (busy),
    .done         (done),
    .converged    (converged),
    .timeout_err  (timeout_err),
    .iter_count   (iter_count),
    .alpha_out    (alpha_out),
    .point_action (point_action)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t sb_q[$];
  int start_cyc = 0;
  int eng_mode  = M_PLUS1;
  int eng_lat   = 3;
  alpha_vec_t prev_alpha = '0;
  act_vec_t   prev_act   = '0;

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  // Engine behaviour per element, wrapped to a W-bit signed value.
  function automatic int eng_elem(input int mode, input int v);
    case (mode)
      M_PLUS1: return (v == 32767) ? -32768 : v + 1;
      M_IDENT: return v;
      M_CONST: return 32767;
      M_HALVE: return v >>> 1;
      default: return v;
    endcase
  endfunction

  // Whole-solve reference: iterate the engine function over integer alpha
  // values until the budget runs out or max |new-cur| <= epsilon.
  function automatic exp_t model(input alpha_vec_t ain, input int mi, input int eps,
                                 input int mode, input int lat, input act_vec_t pact);
    exp_t e;
    int cur[NP][NS];
    int nw[NP][NS];
    int d;
    int dmax;
    e.conv = 1'b0; e.tmo = 1'b0; e.iters = 0; e.nstep = 0; e.lat = 2;
    e.alpha = ain; e.act = pact;
    for (int p = 0; p < NP; p++)
      for (int s = 0; s < NS; s++) cur[p][s] = int'($signed(ain[p][s]));
    if (mi == 0) return e;
    if (mode == M_SILENT) begin
      e.tmo = 1'b1; e.nstep = 1; e.lat = 3 + TMO;
      return e;
    end
    for (int k = 1; k <= mi; k++) begin
      dmax = 0;
      for (int p = 0; p < NP; p++)
        for (int s = 0; s < NS; s++) begin
          nw[p][s] = eng_elem(mode, cur[p][s]);
          d = nw[p][s] - cur[p][s];
          if (d < 0) d = -d;
          if (d > dmax) dmax = d;
        end
      e.iters = k;
      e.nstep = k;
      // done appears the cycle after the last scan cycle of iteration k
      e.lat = 2 + k * (1 + lat + NP * NS);
      for (int p = 0; p < NP; p++) begin
        for (int s = 0; s < NS; s++) e.alpha[p][s] = W'(nw[p][s]);
        e.act[p] = AW'((p + k) % NA);
      end
      if (dmax <= eps) begin
        e.conv = 1'b1;
        break;
      end
      cur = nw;
    end
    return e;
  endfunction

  // Backup engine: answers each step_en after eng_lat cycles (or never when silent).
  initial begin : engine
    int calls;
    alpha_vec_t snap;
    alpha_vec_t res;
    act_vec_t   act;
    calls = 0;
    sif.step_done = 1'b0;
    sif.step_alpha_res = '0;
    sif.step_action_res = '0;
    forever begin
      @(negedge clk);
      if (!busy) calls = 0;
      if (sif.step_en) begin
        calls++;
        snap = sif.step_alpha;
        for (int p = 0; p < NP; p++) begin
          for (int s = 0; s < NS; s++)
            res[p][s] = W'(eng_elem(eng_mode, int'($signed(snap[p][s]))));
          act[p] = AW'((p + calls) % NA);
        end
        repeat (eng_lat) @(negedge clk);
        if (eng_mode != M_SILENT) begin
          sif.step_done = 1'b1;
          sif.step_alpha_res = res;
          sif.step_action_res = act;
          @(negedge clk);
          sif.step_done = 1'b0;
        end
      end
    end
  end

  // Monitor: pop the expected result whenever the DUT signals done.
  initial begin : monitor
    int step_cnt;
    exp_t e;
    step_cnt = 0;
    forever begin
      @(negedge clk);
      if (sif.step_en) step_cnt++;
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 512'(done), 512'(0));
        end else begin
          e = sb_q.pop_front();
          chk("iter_count", 512'(iter_count), 512'(e.iters));
          chk("converged", 512'(converged), 512'(e.conv));
          chk("timeout_err", 512'(timeout_err), 512'(e.tmo));
          chk("alpha_out", 512'(alpha_out), 512'(e.alpha));
          chk("point_action", 512'(point_action), 512'(e.act));
          chk("done_latency", 512'(cyc - start_cyc), 512'(e.lat));
          chk("step_en_count", 512'(step_cnt), 512'(e.nstep));
          $display("solve: iters=%0d conv=%0b tmo=%0b lat=%0d", iter_count, converged,
                   timeout_err, cyc - start_cyc);
        end
      end
      if (!busy && !done) step_cnt = 0;
    end
  end

  task automatic run_solve(input alpha_vec_t ain, input int mi, input int eps,
                           input int mode, input int lat, input bit stray_start);
    exp_t e;
    int budget;
    e = model(ain, mi, eps, mode, lat, prev_act);
    prev_alpha = e.alpha;
    prev_act = e.act;
    sb_q.push_back(e);
    @(negedge clk);
    alpha_in = ain;
    max_iter = 16'(mi);
    epsilon = W'(eps);
    eng_mode = mode;
    eng_lat = lat;
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    if (stray_start && mi > 0) begin
      repeat (3) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    budget = 3000;
    while (sb_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb_q.size() != 0) begin
      chk("done_wait_expired", 512'(0), 512'(1));
      sb_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic alpha_vec_t rand_alpha();
    alpha_vec_t a;
    for (int p = 0; p < NP; p++)
      for (int s = 0; s < NS; s++) a[p][s] = W'($urandom_range(0, 65535));
    return a;
  endfunction

  initial begin : stim
    alpha_vec_t a;
    int budget;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    max_iter = '0;
    epsilon = '0;
    alpha_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_done", 512'(done), 512'(0));
    chk("rst_converged", 512'(converged), 512'(0));
    chk("rst_timeout_err", 512'(timeout_err), 512'(0));
    chk("rst_iter_count", 512'(iter_count), 512'(0));
    chk("rst_alpha_out", 512'(alpha_out), 512'(0));
    chk("rst_point_action", 512'(point_action), 512'(0));
    chk("rst_step_en", 512'(sif.step_en), 512'(0));

    // Budget-limited run: +1 engine never converges at epsilon 0.
    run_solve(rand_alpha(), 4, 0, M_PLUS1, 3, 1'b0);
    // Identical result converges after one backup.
    run_solve(rand_alpha(), 10, 0, M_IDENT, 3, 1'b0);
    // Zero budget: straight to done with the loaded set.
    run_solve(rand_alpha(), 0, 0, M_PLUS1, 3, 1'b0);
    // Silent engine: watchdog expiry.
    run_solve(rand_alpha(), 5, 0, M_SILENT, 3, 1'b0);
    // Signed extremes: 0x8000 -> 0x7FFF gives a 0xFFFF difference.
    for (int p = 0; p < NP; p++)
      for (int s = 0; s < NS; s++) a[p][s] = 16'h8000;
    run_solve(a, 5, 65535, M_CONST, 2, 1'b0);
    run_solve(a, 5, 65534, M_CONST, 2, 1'b0);

    // Abort in WAIT; the engine's late answer arrives as a stray step_done.
    @(negedge clk);
    alpha_in = rand_alpha();
    max_iter = 16'd5;
    epsilon = '0;
    eng_mode = M_PLUS1;
    eng_lat = 12;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    budget = 20;
    while (!sif.step_en && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("abort_step_en_seen", 512'(sif.step_en), 512'(1));
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 512'(busy), 512'(0));
    chk("abort_alpha_hold", 512'(alpha_out), 512'(prev_alpha));
    chk("abort_action_hold", 512'(point_action), 512'(prev_act));
    chk("abort_iter_count", 512'(iter_count), 512'(0));
    repeat (20) @(negedge clk);
    chk("abort_busy_after_stray", 512'(busy), 512'(0));
    run_solve(rand_alpha(), 3, 0, M_PLUS1, 4, 1'b0);

    // Randomized solves with random engine behaviour and occasional start while busy.
    for (int r = 0; r < 20; r++) begin
      int mode;
      int mi;
      int eps;
      mode = ($urandom_range(0, 9) == 0) ? M_SILENT : int'($urandom_range(0, 3));
      mi = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
      eps = (mode == M_HALVE) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 2));
      run_solve(rand_alpha(), mi, eps, mode, int'($urandom_range(1, 8)),
                bit'($urandom_range(0, 1)));
    end

    chk("scoreboard_empty", 512'(sb_q.size()), 512'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
